// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures the half-period of tone_in, matches it
// against the melody note table and reports a debounced note code.
module tone_decoder #(
  parameter int TOL         = 8,
  parameter int CONFIRM     = 4,
  parameter int SILENCE_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tone_in,
  output logic [2:0]  note_id,
  output logic [15:0] half_period,
  output logic        active,
  output logic        note_valid
);

  typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;

  localparam logic [16:0] SIL_MAX = 17'(SILENCE_CYC);
  localparam logic [16:0] TOL_V   = 17'(TOL);
  localparam logic [3:0]  CONF    = 4'(CONFIRM);

  state_t      state, state_nxt;
  logic        sync1, sync2, sync_d, edge_r;
  logic [16:0] cnt, est;
  logic [2:0]  code, run_code, run_code_nxt;
  logic [3:0]  run_len, run_len_nxt;
  logic        confirm, take_meas, update, go_silent, silence_hit;

  function automatic logic [15:0] table_val(input logic [2:0] c);
    case (c)
      3'd1:    table_val = 16'd637;
      3'd2:    table_val = 16'd758;
      3'd3:    table_val = 16'd851;
      3'd4:    table_val = 16'd955;
      3'd5:    table_val = 16'd1012;
      3'd6:    table_val = 16'd1136;
      3'd7:    table_val = 16'd1275;
      default: table_val = 16'd0;
    endcase
  endfunction

  // Synchronizer keeps tracking while disabled so re-enabling sees no stale edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync1  <= tone_in;
      sync2  <= sync1;
      sync_d <= sync2;
      edge_r <= en & (sync2 ^ sync_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (!en)
      cnt <= '0;
    else if (edge_r)
      cnt <= 17'd1;
    else if (cnt < SIL_MAX)
      cnt <= cnt + 17'd1;
  end

  assign est         = (cnt == '0) ? '0 : cnt - 17'd1;
  assign silence_hit = (cnt == SIL_MAX);

  // Table values are at least 57 apart, so with TOL < 28 at most one code matches
  always_comb begin
    logic [16:0] tv;
    logic [16:0] diff;
    code = '0;
    tv   = '0;
    diff = '0;
    for (int i = 1; i < 8; i++) begin
      tv   = {1'b0, table_val(3'(i))};
      diff = (est >= tv) ? (est - tv) : (tv - est);
      if (diff <= TOL_V)
        code = 3'(i);
    end
  end

  always_comb begin
    run_code_nxt = run_code;
    run_len_nxt  = run_len;
    if (code == '0) begin
      run_code_nxt = '0;
      run_len_nxt  = '0;
    end else if (code != run_code) begin
      run_code_nxt = code;
      run_len_nxt  = 4'd1;
    end else if (run_len < CONF) begin
      run_len_nxt = run_len + 4'd1;
    end
  end

  assign confirm = (code != '0) && (code == run_code) && (run_len == CONF - 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= SILENT;
    else if (!en)
      state <= SILENT;
    else
      state <= state_nxt;
  end

  // An edge takes priority over the silence threshold on the same cycle
  always_comb begin
    state_nxt = state;
    take_meas = 1'b0;
    update    = 1'b0;
    go_silent = 1'b0;
    case (state)
      SILENT: begin
        if (edge_r)
          state_nxt = ACQUIRE;
      end
      ACQUIRE: begin
        if (edge_r) begin
          take_meas = 1'b1;
          if (confirm) begin
            state_nxt = LOCKED;
            update    = 1'b1;
          end
        end else if (silence_hit) begin
          state_nxt = SILENT;
          go_silent = 1'b1;
        end
      end
      LOCKED: begin
        if (edge_r) begin
          take_meas = 1'b1;
          update    = confirm && (code != note_id);
        end else if (silence_hit) begin
          state_nxt = SILENT;
          go_silent = 1'b1;
        end
      end
      default: state_nxt = SILENT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_code    <= '0;
      run_len     <= '0;
      note_id     <= '0;
      half_period <= '0;
      active      <= 1'b0;
      note_valid  <= 1'b0;
    end else if (!en) begin
      run_code    <= '0;
      run_len     <= '0;
      note_id     <= '0;
      half_period <= '0;
      active      <= 1'b0;
      note_valid  <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (take_meas) begin
        run_code <= run_code_nxt;
        run_len  <= run_len_nxt;
      end
      if (update) begin
        note_id     <= code;
        half_period <= table_val(code);
        active      <= 1'b1;
        note_valid  <= 1'b1;
      end
      if (go_silent) begin
        run_code    <= '0;
        run_len     <= '0;
        note_id     <= '0;
        half_period <= '0;
        active      <= 1'b0;
        note_valid  <= (note_id != 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: table of single-note locks plus hand-written
// sequences for note change, glitch, silence, enable and reset behaviour.
module tb_tone_decoder;

  localparam int SIL = 1500;

  logic        clk;
  logic        rst;
  logic        en;
  logic        tone_in;
  logic [2:0]  note_id;
  logic [15:0] half_period;
  logic        active;
  logic        note_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int consec = 0;
  int id_changes = 0;
  int pulse_cyc = 0;
  int last_toggle_cyc = 0;
  int base;
  logic [2:0]  strobe_id = '0;
  logic [15:0] strobe_hp = '0;
  logic        strobe_active = 1'b0;
  logic        prev_valid = 1'b0;
  logic [2:0]  prev_id = '0;

  typedef struct {
    int          hold;
    logic [2:0]  exp_id;
    logic [15:0] exp_hp;
    logic        exp_active;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[7];

  tone_decoder #(.TOL(8), .CONFIRM(4), .SILENCE_CYC(SIL)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .tone_in(tone_in),
    .note_id(note_id),
    .half_period(half_period),
    .active(active),
    .note_valid(note_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (note_valid) begin
      pulses        = pulses + 1;
      strobe_id     = note_id;
      strobe_hp     = half_period;
      strobe_active = active;
      pulse_cyc     = cyc;
    end
    if (note_valid && prev_valid)
      consec = consec + 1;
    prev_valid = note_valid;
    if (note_id != prev_id)
      id_changes = id_changes + 1;
    prev_id = note_id;
  end

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks = checks + 1;
    if (actual < lo || actual > hi) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Toggles tone_in n times, holding each new level for hold cycles
  task automatic applyStimulus(input int hold, input int n);
    for (int k = 0; k < n; k++) begin
      tone_in = ~tone_in;
      last_toggle_cyc = cyc;
      repeat (hold) tick();
    end
  endtask

  task automatic clearDecoder();
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    vecs[0] = '{hold: 638,  exp_id: 3'd1, exp_hp: 16'd637,  exp_active: 1'b1, exp_pulses: 1};
    vecs[1] = '{hold: 852,  exp_id: 3'd3, exp_hp: 16'd851,  exp_active: 1'b1, exp_pulses: 1};
    vecs[2] = '{hold: 956,  exp_id: 3'd4, exp_hp: 16'd955,  exp_active: 1'b1, exp_pulses: 1};
    vecs[3] = '{hold: 1013, exp_id: 3'd5, exp_hp: 16'd1012, exp_active: 1'b1, exp_pulses: 1};
    vecs[4] = '{hold: 1137, exp_id: 3'd6, exp_hp: 16'd1136, exp_active: 1'b1, exp_pulses: 1};
    vecs[5] = '{hold: 767,  exp_id: 3'd2, exp_hp: 16'd758,  exp_active: 1'b1, exp_pulses: 1};
    vecs[6] = '{hold: 768,  exp_id: 3'd0, exp_hp: 16'd0,    exp_active: 1'b0, exp_pulses: 0};

    rst = 1'b0;
    en = 1'b1;
    tone_in = 1'b0;
    repeat (5) tick();
    checkOutput("reset_note_id", note_id, 0);
    checkOutput("reset_half_period", half_period, 0);
    checkOutput("reset_active", active, 0);
    checkOutput("reset_note_valid", note_valid, 0);
    rst = 1'b1;
    base = pulses;
    repeat (2 * SIL) tick();
    checkOutput("idle_pulses", pulses - base, 0);
    checkOutput("idle_note_id", note_id, 0);
    checkOutput("idle_active", active, 0);

    for (int v = 0; v < 7; v++) begin
      clearDecoder();
      base = pulses;
      applyStimulus(vecs[v].hold, 4);
      checkOutput($sformatf("v%0d_early_lock", v), pulses - base, 0);
      applyStimulus(vecs[v].hold, 1);
      checkOutput($sformatf("v%0d_note_id", v), note_id, vecs[v].exp_id);
      checkOutput($sformatf("v%0d_half_period", v), half_period, vecs[v].exp_hp);
      checkOutput($sformatf("v%0d_active", v), active, vecs[v].exp_active);
      checkOutput($sformatf("v%0d_pulses", v), pulses - base, vecs[v].exp_pulses);
    end

    $display("[TB] lock on 759-cycle levels, then change to 956");
    clearDecoder();
    base = pulses;
    applyStimulus(759, 5);
    checkOutput("lock_strobe_id", strobe_id, 2);
    checkOutput("lock_strobe_hp", strobe_hp, 758);
    checkOutput("lock_strobe_active", strobe_active, 1);
    applyStimulus(759, 4);
    checkOutput("lock_single_pulse", pulses - base, 1);
    id_changes = 0;
    base = pulses;
    applyStimulus(956, 7);
    checkOutput("change_pulses", pulses - base, 1);
    checkOutput("change_strobe_id", strobe_id, 4);
    checkOutput("change_strobe_hp", strobe_hp, 955);
    checkOutput("change_id_steps", id_changes, 1);
    checkOutput("change_note_id", note_id, 4);

    $display("[TB] glitch and silence while locked on code 7");
    clearDecoder();
    applyStimulus(1276, 5);
    checkOutput("c7_note_id", note_id, 7);
    base = pulses;
    id_changes = 0;
    tone_in = ~tone_in;
    repeat (600) tick();
    tone_in = ~tone_in;
    repeat (2) tick();
    tone_in = ~tone_in;
    repeat (674) tick();
    applyStimulus(1276, 5);
    checkOutput("glitch_pulses", pulses - base, 0);
    checkOutput("glitch_id_steps", id_changes, 0);
    checkOutput("glitch_note_id", note_id, 7);
    strobe_id = 3'd7;
    strobe_hp = 16'hFFFF;
    strobe_active = 1'b1;
    for (int w = 0; w < 2 * SIL && pulses == base; w++)
      tick();
    checkOutput("silence_pulse", pulses - base, 1);
    checkRange("silence_delay", pulse_cyc - last_toggle_cyc, SIL, SIL + 7);
    checkOutput("silence_strobe_id", strobe_id, 0);
    checkOutput("silence_strobe_hp", strobe_hp, 0);
    checkOutput("silence_strobe_active", strobe_active, 0);

    $display("[TB] enable drop, re-enable, reset mid-lock");
    clearDecoder();
    base = pulses;
    applyStimulus(759, 5);
    checkOutput("en_pre_note_id", note_id, 2);
    en = 1'b0;
    repeat (2) tick();
    checkOutput("en_off_note_id", note_id, 0);
    checkOutput("en_off_half_period", half_period, 0);
    checkOutput("en_off_active", active, 0);
    checkOutput("en_off_pulses", pulses - base, 1);
    en = 1'b1;
    repeat (4) tick();
    base = pulses;
    applyStimulus(1276, 5);
    checkOutput("reen_note_id", note_id, 7);
    checkOutput("reen_half_period", half_period, 1275);
    checkOutput("reen_pulses", pulses - base, 1);
    rst = 1'b0;
    #1;
    checkOutput("arst_note_id", note_id, 0);
    checkOutput("arst_half_period", half_period, 0);
    checkOutput("arst_active", active, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("arst_pulses", pulses - base, 1);
    checkOutput("arst_after_note_id", note_id, 0);

    checkOutput("no_back_to_back", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
